eth_pkt_tx: RTL and testbench

//  Frame transmitter driving one switch ingress port (32-bit word stream, sop/eop).

---
 rtl/eth_pkg.sv | 29 ++
 rtl/eth_pkt_tx.sv | 153 +++++++++++++++
 tb/tb_eth_pkt_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and header layout for the switch-port frame transmitter (eth_pkt_tx).
package eth_pkg;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, GAP} tx_state_t;

  localparam int HDR_DA_LSB  = 0;
  localparam int HDR_LEN_LSB = 8;
  localparam int HDR_SEQ_LSB = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        valid;
  } eth_word_t;

  // Bits [7:4] stay zero.
  function automatic logic [31:0] make_header(input logic [3:0]  da,
                                              input logic [7:0]  len,
                                              input logic [15:0] seq);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_DA_LSB  +: 4]  = da;
    hdr[HDR_LEN_LSB +: 8]  = len;
    hdr[HDR_SEQ_LSB +: 16] = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/eth_pkt_tx.sv
// Frame transmitter: header + payload words (+ XOR trailer when CHECKSUM_EN is defined),
// registered output honouring tx_stall, followed by an IFG-cycle inter-frame gap.
module eth_pkt_tx
  import eth_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int IFG   = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [3:0]       desc_da,
  input  logic [LEN_W-1:0] desc_len,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic [31:0]      pl_data,
  output logic [31:0]      tx_data,
  output logic             tx_valid,
  output logic             tx_sop,
  output logic             tx_eop,
  input  logic             tx_stall,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  tx_state_t        state_q, state_d;
  eth_word_t        tx_q, tx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [15:0]      gap_q, gap_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
`ifdef CHECKSUM_EN
  logic [31:0]      csum_q, csum_d;
`endif

  logic        reg_free, xfer, eop_xfer, desc_hs, pl_hs;
  logic [31:0] header;

  assign reg_free = !tx_q.valid || !tx_stall;
  assign xfer     = tx_q.valid && !tx_stall;
  assign eop_xfer = xfer && tx_q.eop;

  // Gated by resetN so nothing is accepted while reset is asserted.
  assign desc_ready = resetN && (state_q == IDLE) && reg_free;
  assign pl_ready   = resetN && (state_q == PAYLOAD) && reg_free && (rem_q != '0);
  assign desc_hs    = desc_valid && desc_ready;
  assign pl_hs      = pl_valid && pl_ready;

  assign header = make_header(desc_da, 8'(desc_len), frame_cnt_q);

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave one unassigned (no latches).
    state_d     = state_q;
    tx_d        = tx_q;
    rem_d       = rem_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q + 16'(eop_xfer);
`ifdef CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (reg_free) begin
      tx_d.valid = 1'b0;
      tx_d.sop   = 1'b0;
      tx_d.eop   = 1'b0;
    end

    case (state_q)
      IDLE: if (desc_hs) begin
        tx_d  = '{data: header, sop: 1'b1, eop: 1'b0, valid: 1'b1};
        rem_d = desc_len;
`ifdef CHECKSUM_EN
        csum_d  = header;
        state_d = (desc_len == '0) ? CSUM : PAYLOAD;
`else
        if (desc_len == '0) begin
          tx_d.eop = 1'b1;
          state_d  = GAP;
        end else begin
          state_d  = PAYLOAD;
        end
`endif
      end

      PAYLOAD: if (pl_hs) begin
        tx_d  = '{data: pl_data, sop: 1'b0, eop: 1'b0, valid: 1'b1};
        rem_d = rem_q - LEN_W'(1);
`ifdef CHECKSUM_EN
        csum_d = csum_q ^ pl_data;
        if (rem_q == LEN_W'(1)) state_d = CSUM;
`else
        if (rem_q == LEN_W'(1)) begin
          tx_d.eop = 1'b1;
          state_d  = GAP;
        end
`endif
      end

`ifdef CHECKSUM_EN
      CSUM: if (reg_free) begin
        tx_d    = '{data: csum_q, sop: 1'b0, eop: 1'b1, valid: 1'b1};
        state_d = GAP;
      end
`endif

      // The gap count starts only once the pending eop word has actually transferred.
      GAP: begin
        if (tx_q.valid) begin
          if (xfer) begin
            if (IFG == 0) state_d = IDLE;
            else          gap_d   = 16'(IFG);
          end
        end else if (gap_q <= 16'd1) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; every flop has a reset value.
    if (!resetN) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rem_q       <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
`ifdef CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign tx_data   = tx_q.data;
  assign tx_valid  = tx_q.valid;
  assign tx_sop    = tx_q.sop;
  assign tx_eop    = tx_q.eop;
  assign busy      = (state_q != IDLE) || tx_q.valid;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_pkt_tx.sv
// Directed self-checking bench for eth_pkt_tx (default IFG=2; CHECKSUM_EN-aware).
module tb_eth_pkt_tx;

  localparam int IFG = 2;
  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WB = 32'hBBBB_0002;
  localparam logic [31:0] WC = 32'hCCCC_0003;

  logic        clk = 1'b0;
  logic        resetN;
  logic        desc_valid, desc_ready;
  logic [3:0]  desc_da;
  logic [7:0]  desc_len;
  logic        pl_valid, pl_ready;
  logic [31:0] pl_data;
  logic [31:0] tx_data;
  logic        tx_valid, tx_sop, tx_eop, tx_stall, busy;
  logic [15:0] frame_cnt;

  eth_pkt_tx #(.LEN_W(8), .IFG(IFG)) dut (
    .clk(clk), .resetN(resetN),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_da(desc_da), .desc_len(desc_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_stall(tx_stall), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] pl_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_data[$];
  logic        got_sop[$];
  logic        got_eop[$];
  int          got_cyc[$];
  int          gap_cycles;
  int          b_seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0; desc_valid = 1'b0; pl_valid = 1'b0; tx_stall = 1'b0;
    desc_da = '0; desc_len = '0; pl_data = '0;
    tick();
    tick();
    resetN = 1'b1;
    #1;
  endtask

  // Offers one descriptor plus pl_q; optionally stalls stall_cycles while pl_q[stall_word] is shown.
  task automatic run_frame(input logic [3:0] da, input logic [7:0] len,
                           input int stall_word, input int stall_cycles);
    int  pl_idx = 0;
    int  stall_left = stall_cycles;
    int  eop_cyc = -1;
    bit  desc_pending = 1'b1;
    bit  done = 1'b0;
    got_data.delete(); got_sop.delete(); got_eop.delete(); got_cyc.delete();
    gap_cycles = -1;
    b_seen = 0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      tick();
      desc_valid = desc_pending;
      desc_da    = da;
      desc_len   = len;
      pl_valid   = (pl_idx < pl_q.size());
      pl_data    = pl_valid ? pl_q[pl_idx] : 32'h0;
      tx_stall   = 1'b0;
      if (stall_word >= 0 && stall_word < pl_q.size() && tx_valid && !tx_sop &&
          tx_data == pl_q[stall_word] && stall_left > 0) begin
        tx_stall = 1'b1;
        stall_left--;
      end
      #1;
      if (stall_word >= 0 && stall_word < pl_q.size() && tx_valid && tx_data == pl_q[stall_word])
        b_seen++;
      if (tx_stall) begin
        check("stall_pl_ready", pl_ready, 1'b0);
        check("stall_desc_ready", desc_ready, 1'b0);
      end
      if (desc_valid && desc_ready) desc_pending = 1'b0;
      if (pl_valid && pl_ready) pl_idx++;
      if (eop_cyc >= 0 && desc_ready) begin
        gap_cycles = cyc - eop_cyc - 1;
        done = 1'b1;
      end
      if (tx_valid && !tx_stall) begin
        got_data.push_back(tx_data);
        got_sop.push_back(tx_sop);
        got_eop.push_back(tx_eop);
        got_cyc.push_back(cyc);
        if (tx_eop) eop_cyc = cyc;
      end
    end
    desc_valid = 1'b0; pl_valid = 1'b0; tx_stall = 1'b0;
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nwords"}, got_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_w%0d_data", tag, i), got_data[i], exp_q[i]);
      check($sformatf("%s_w%0d_sop", tag, i), got_sop[i], (i == 0));
      check($sformatf("%s_w%0d_eop", tag, i), got_eop[i], (i == exp_q.size() - 1));
    end
  endtask

  initial begin
    // Reset
    resetN = 1'b0; desc_valid = 1'b0; pl_valid = 1'b0; tx_stall = 1'b0;
    desc_da = '0; desc_len = '0; pl_data = '0;
    tick();
    tick();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_desc_ready", desc_ready, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_busy", busy, 1'b0);
    resetN = 1'b1;
    #1;
    check("post_rst_desc_ready", desc_ready, 1'b1);

    // da=2, len=3, no stall
    pl_q = '{WA, WB, WC};
    exp_q = '{32'h0000_0302, WA, WB, WC};
`ifdef CHECKSUM_EN
    exp_q.push_back(32'h0000_0302 ^ WA ^ WB ^ WC);
`endif
    run_frame(4'd2, 8'd3, -1, 0);
    check_frame("f1");
    if (got_cyc.size() == exp_q.size())
      check("f1_back_to_back", got_cyc[got_cyc.size()-1] - got_cyc[0], exp_q.size() - 1);
    check("f1_gap", gap_cycles, IFG);
    check("f1_frame_cnt", frame_cnt, 16'd1);

    // Same frame, B stalled 3 cycles; header carries seq=1
    exp_q = '{32'h0001_0302, WA, WB, WC};
`ifdef CHECKSUM_EN
    exp_q.push_back(32'h0001_0302 ^ WA ^ WB ^ WC);
`endif
    run_frame(4'd2, 8'd3, 1, 3);
    check_frame("f2");
    check("f2_b_held", b_seen, 4);
    check("f2_gap", gap_cycles, IFG);
    check("f2_frame_cnt", frame_cnt, 16'd2);

    // Reset dropped mid-payload
    tick();
    desc_valid = 1'b1; desc_da = 4'd3; desc_len = 8'd4;
    pl_valid = 1'b1; pl_data = 32'h1234_5678;
    tick();
    desc_valid = 1'b0;
    tick();
    check("mid_tx_valid", tx_valid, 1'b1);
    check("mid_busy", busy, 1'b1);
    check("mid_frame_cnt", frame_cnt, 16'd2);
    resetN = 1'b0;
    tick();
    check("abort_tx_valid", tx_valid, 1'b0);
    check("abort_tx_eop", tx_eop, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_frame_cnt", frame_cnt, 16'd0);
    resetN = 1'b1;
    pl_valid = 1'b0;
    #1;
    check("abort_idle_ready", desc_ready, 1'b1);

    // len=0, da=5
    pl_q.delete();
`ifdef CHECKSUM_EN
    exp_q = '{32'h0000_0005, 32'h0000_0005};
`else
    exp_q = '{32'h0000_0005};
`endif
    run_frame(4'd5, 8'd0, -1, 0);
    check_frame("len0");
    check("len0_gap", gap_cycles, IFG);
    check("len0_frame_cnt", frame_cnt, 16'd1);

`ifdef CHECKSUM_EN
    // XOR trailer, da=1 len=2 with seq=0
    do_reset();
    pl_q = '{32'hF0F0_0000, 32'h0000_0F0F};
    exp_q = '{32'h0000_0201, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0D0E};
    run_frame(4'd1, 8'd2, -1, 0);
    check_frame("csum");
    check("csum_frame_cnt", frame_cnt, 16'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
